router_out_fifo: RTL

Per-destination output buffer of the 1x3 router: stores bytes routed to one of the three ports and drives the read-side pins `data_out`/`vld_out` under `read_enb`. It tags header bytes to track packet boundaries for downstream monitoring. It also runs the read-timeout: if the destination leaves data unread for `TIMEOUT` cycles, the block flushes itself and reports `soft_reset`. Three instances sit between the router FSM/register stage and the read interface.

---
 rtl/router_out_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/router_out_fifo.sv
// Per-port output buffer: registered pop (1-cycle read latency), header tagging for packet-end pulse,
// and a read-timeout flush. Pushes are dropped when full; pops are ignored when empty (no fall-through).
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_done,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [6:0]      pkt_cnt;
  logic [TW-1:0]   to_cnt;
  logic [WIDTH:0]  rd_entry;
  logic            push, pop, timeout_hit;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign vld_out  = ~empty;
  assign push     = write_enb && !full;
  assign pop      = read_enb && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];
  // Flush on the edge that would take the unread-cycle count to TIMEOUT.
  assign timeout_hit = vld_out && !read_enb && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (push && !timeout_hit && !reset)
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      to_cnt     <= '0;
      data_out   <= '0;
      pkt_done   <= 1'b0;
      soft_reset <= 1'b0;
    end else if (timeout_hit) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      to_cnt     <= '0;
      data_out   <= '0;
      pkt_done   <= 1'b0;
      soft_reset <= 1'b1;
    end else begin
      soft_reset <= 1'b0;
      pkt_done   <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry[WIDTH-1:0];
        // Header carries payload length in [7:2]; +1 counts the parity byte.
        if (rd_entry[WIDTH])
          pkt_cnt <= 7'(rd_entry[WIDTH-1:2]) + 7'd1;
        else if (pkt_cnt != 7'd0) begin
          pkt_cnt  <= pkt_cnt - 7'd1;
          pkt_done <= (pkt_cnt == 7'd1);
        end
      end
      if (vld_out && !read_enb)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
    end
  end

endmodule
